fifo_param_thr: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed 12-bit/8-entry channel FIFO.
- Data width and depth are generic. Almost-full and almost-empty thresholds are programmable at runtime.
- Exposes an occupancy count, single-cycle overflow/underflow pulses and a sticky error flag with software clear.
- Used as the per-channel buffer in the queue/arbiter datapath.

---
 rtl/fifo_param_thr_pkg.sv | 22 ++
 rtl/fifo_param_thr_mem_2p.sv | 24 ++
 rtl/fifo_param_thr.sv | 89 ++++++++
 tb/tb_fifo_param_thr.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_thr_pkg.sv
// Shared defaults and width helpers for the parametrised channel FIFO.
package fifo_param_thr_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 3;

  function automatic int clog2(input int value);
    int res = 0;
    int v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Counts must represent 0..DEPTH inclusive, hence one state more than DEPTH.
  function automatic int cnt_width(input int addr_w);
    return clog2((1 << addr_w) + 1);
  endfunction

endpackage

// File: rtl/fifo_param_thr_mem_2p.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module fifo_param_thr_mem_2p
  import fifo_param_thr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_thr.sv
// Parametrised synchronous FIFO with runtime almost-full/empty thresholds,
// occupancy count, overflow/underflow pulses and a sticky error flag.
module fifo_param_thr
  import fifo_param_thr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = cnt_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic [CNT_W-1:0]  th_almost_full,
  input  logic [CNT_W-1:0]  th_almost_empty,
  input  logic              err_clear,
  output logic [DATA_W-1:0] fifo_data_out,
  output logic              valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow,
  output logic              underflow,
  output logic              fifo_error
);

  localparam logic [CNT_W-1:0] PTR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;
  logic              unf_evt;

  // Pointers carry one wrap bit above the address so full and empty differ.
  assign occupancy    = wr_ptr - rd_ptr;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
  assign almost_full  = (occupancy >= th_almost_full);
  assign almost_empty = (occupancy <= th_almost_empty);

  assign rd_acc  = read & ~fifo_empty;
  assign wr_acc  = write & (~fifo_full | rd_acc);
  assign ovf_evt = write & fifo_full & ~rd_acc;
  assign unf_evt = read & fifo_empty;

  fifo_param_thr_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_data_out <= '0;
      valid         <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      fifo_error    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        fifo_data_out <= mem_rdata;
      end
      valid     <= rd_acc;
      overflow  <= ovf_evt;
      underflow <= unf_evt;
      // A new error in the same cycle as a clear keeps the flag set.
      if (ovf_evt || unf_evt) fifo_error <= 1'b1;
      else if (err_clear)     fifo_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_param_thr.sv
// Self-checking bench for fifo_param_thr against a queue-based reference model.
module tb_fifo_param_thr;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              write = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read = 1'b0;
  logic [CNT_W-1:0]  th_almost_full = 4'd6;
  logic [CNT_W-1:0]  th_almost_empty = 4'd1;
  logic              err_clear = 1'b0;
  logic [DATA_W-1:0] fifo_data_out;
  logic              valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  occupancy;
  logic              overflow;
  logic              underflow;
  logic              fifo_error;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid;
  logic              exp_ovf;
  logic              exp_unf;
  logic              exp_err;

  fifo_param_thr #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .write           (write),
    .data_in         (data_in),
    .read            (read),
    .th_almost_full  (th_almost_full),
    .th_almost_empty (th_almost_empty),
    .err_clear       (err_clear),
    .fifo_data_out   (fifo_data_out),
    .valid           (valid),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .occupancy       (occupancy),
    .overflow        (overflow),
    .underflow       (underflow),
    .fifo_error      (fifo_error)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Drives one clock of stimulus and advances the model; returns at edge+1.
  task automatic cycle(input logic w, input logic [DATA_W-1:0] d,
                       input logic r, input logic clr);
    int   n;
    logic ra;
    write = w; data_in = d; read = r; err_clear = clr;
    n  = q.size();
    ra = r && (n > 0);
    exp_ovf   = w && (n == DEPTH) && !ra;
    exp_unf   = r && (n == 0);
    exp_valid = ra;
    if (ra) exp_data = q.pop_front();
    if (w && ((n < DEPTH) || ra)) q.push_back(d);
    if (exp_ovf || exp_unf) exp_err = 1'b1;
    else if (clr)           exp_err = 1'b0;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fifo_empty, fifo_full, occupancy, valid, fifo_data_out, overflow, underflow, fifo_error}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values got e%b f%b occ%0d v%b d%h o%b u%b err%b",
               fifo_empty, fifo_full, occupancy, valid, fifo_data_out, overflow, underflow, fifo_error);
    end
    checks++;
    if ({almost_empty, almost_full} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_almost got ae%b af%b expected ae1 af0", almost_empty, almost_full);
    end
    reset_L = 1'b1;
    model_reset();
    cycle(1'b1, 12'h3A1, 1'b0, 1'b0);
    cycle(1'b1, 12'h3A2, 1'b0, 1'b0);
    #3 reset_L = 1'b0;
    #1;
    checks++;
    if ({fifo_empty, occupancy, valid, fifo_error} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_async got e%b occ%0d v%b err%b expected e1 occ0 v0 err0",
               fifo_empty, occupancy, valid, fifo_error);
    end
    @(posedge clk); #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_full();
    th_almost_full  = 4'd6;
    th_almost_empty = 4'd1;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 12'(i), 1'b0, 1'b0);
      checks++;
      if (almost_full !== (i >= 6) || occupancy !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL fill_step%0d got af%b occ%0d expected af%b occ%0d",
                 i, almost_full, occupancy, (i >= 6), i);
      end
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_empty !== 1'b0 || occupancy !== 4'd8) begin
      errors++;
      $display("[TB] FAIL fill_full got f%b e%b occ%0d expected f1 e0 occ8",
               fifo_full, fifo_empty, occupancy);
    end
  endtask

  task automatic test_overflow_drain();
    cycle(1'b1, 12'hABC, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fifo_error !== 1'b1 || occupancy !== 4'd8) begin
      errors++;
      $display("[TB] FAIL overflow_pulse got o%b err%b occ%0d expected o1 err1 occ8",
               overflow, fifo_error, occupancy);
    end
    cycle(1'b0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0 || fifo_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_one_cycle got o%b err%b expected o0 err1", overflow, fifo_error);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 12'h000, 1'b1, 1'b0);
      checks++;
      if (valid !== 1'b1 || fifo_data_out !== 12'(i)) begin
        errors++;
        $display("[TB] FAIL drain_word%0d got v%b d%h expected v1 d%h", i, valid, fifo_data_out, 12'(i));
      end
    end
    cycle(1'b0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_data_out !== 12'h008) begin
      errors++;
      $display("[TB] FAIL drain_done got v%b e%b d%h expected v0 e1 d008", valid, fifo_empty, fifo_data_out);
    end
  endtask

  task automatic test_pass_through();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 12'h100, 1'b1, 1'b0);
      checks++;
      if (occupancy !== 4'd8 || overflow !== 1'b0 || valid !== 1'b1 || fifo_data_out !== exp_data) begin
        errors++;
        $display("[TB] FAIL pass_through%0d got occ%0d o%b v%b d%h expected occ8 o0 v1 d%h",
                 i, occupancy, overflow, valid, fifo_data_out, exp_data);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 12'h000, 1'b1, 1'b0);
      checks++;
      if (valid !== 1'b1 || fifo_data_out !== ((i < 5) ? 12'h204 + 12'(i) : 12'h100)) begin
        errors++;
        $display("[TB] FAIL wrap_drain%0d got v%b d%h expected v1 d%h", i, valid, fifo_data_out,
                 (i < 5) ? 12'h204 + 12'(i) : 12'h100);
      end
    end
  endtask

  task automatic test_underflow_clear();
    logic [DATA_W-1:0] last;
    last = fifo_data_out;
    cycle(1'b0, 12'h000, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || valid !== 1'b0 || fifo_data_out !== last || fifo_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow got u%b v%b d%h err%b expected u1 v0 d%h err1",
               underflow, valid, fifo_data_out, fifo_error, last);
    end
    cycle(1'b0, 12'h000, 1'b0, 1'b1);
    checks++;
    if (fifo_error !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got err%b u%b expected err0 u0", fifo_error, underflow);
    end
    cycle(1'b0, 12'h000, 1'b1, 1'b1);
    checks++;
    if (fifo_error !== 1'b1 || underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins got err%b u%b expected err1 u1", fifo_error, underflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'h0C0 + 12'(i), 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || fifo_data_out !== 12'h0C0) begin
      errors++;
      $display("[TB] FAIL mid_read got v%b d%h expected v1 d0c0", valid, fifo_data_out);
    end
    read = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if (occupancy !== 4'd0 || fifo_empty !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got occ%0d e%b v%b expected occ0 e1 v0", occupancy, fifo_empty, valid);
    end
    read = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1;
    model_reset();
    cycle(1'b1, 12'h055, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || fifo_data_out !== 12'h055) begin
      errors++;
      $display("[TB] FAIL after_reset got v%b d%h expected v1 d055", valid, fifo_data_out);
    end
  endtask

  task automatic test_random();
    logic [23:0] obs;
    logic [23:0] expv;
    int          wr_bias;
    for (int c = 0; c < 600; c++) begin
      wr_bias = ((c / 100) % 2 == 0) ? 75 : 25;
      if ($urandom_range(0, 9) == 0) begin
        th_almost_full  = 4'($urandom_range(0, 15));
        th_almost_empty = 4'($urandom_range(0, 15));
      end
      cycle($urandom_range(0, 99) < wr_bias, 12'($urandom), $urandom_range(0, 99) < (100 - wr_bias),
            $urandom_range(0, 7) == 0);
      obs  = {occupancy, fifo_empty, fifo_full, almost_full, almost_empty, valid,
              fifo_data_out, overflow, underflow, fifo_error};
      expv = {4'(q.size()), q.size() == 0, q.size() == DEPTH,
              q.size() >= int'(th_almost_full), q.size() <= int'(th_almost_empty), exp_valid,
              exp_data, exp_ovf, exp_unf, exp_err};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d got %h expected %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_full();
    test_overflow_drain();
    test_pass_through();
    test_underflow_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
